// File: rtl/execute_stage.sv
// execute_stage: handshaked integer execute stage between register-read and
// memory/writeback.
//
// Single-cycle ALU operations land in the output registers on the accepting
// edge, so their latency is one cycle. MUL runs on an iterative shift-add unit
// for exactly XLEN cycles. While it runs, in_ready_o stays low.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush_i           drops the in-flight multiply and the output register
//   in_valid_i / in_ready_o    upstream handshake
//   opcode_i, rs1_i, rs2_i, imm_i, rd_i   operation and operands
//   out_valid_o / out_ready_i  downstream handshake
//   opcode_o, rd_o, alu_result_o, illegal_o   registered result
//   busy_o            multiplier active (FSM not IDLE)
module execute_stage #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 20,
    parameter int OPC_W = 5,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [RD_W-1:0]  rd_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OPC_W-1:0] opcode_o,
    output logic [RD_W-1:0]  rd_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic             illegal_o,
    output logic             busy_o
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_SRA  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_SLTU = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_LUI  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(12);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_HOLD = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [XLEN-1:0]  mcand_r, mplier_r, acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [OPC_W-1:0] mul_opc_r;
    logic [RD_W-1:0]  mul_rd_r;

    logic             out_valid_r, illegal_r, busy_r;
    logic [OPC_W-1:0] opcode_r;
    logic [RD_W-1:0]  rd_r;
    logic [XLEN-1:0]  result_r;

    logic             out_free_s, accept_s, is_mul_s, last_step_s;
    logic             start_mul_s, step_mul_s, load_alu_s, load_mul_s, drop_out_s;
    logic             alu_ill_s;
    logic [XLEN-1:0]  imm_s, alu_res_s, acc_next_s, mul_val_s;
    logic [SH_W-1:0]  shamt_s;

    assign imm_s       = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign shamt_s     = rs2_i[SH_W-1:0];
    assign out_free_s  = ~out_valid_r | out_ready_i;
    assign in_ready_o  = (state_r == IDLE) & ~flush_i & out_free_s;
    assign accept_s    = in_valid_i & in_ready_o;
    assign is_mul_s    = (opcode_i == OP_MUL);
    // One shift-add step. The final step's sum goes straight to the output.
    assign acc_next_s  = acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});
    assign last_step_s = (cnt_r == CNT_W'(XLEN-1));

    // Single-cycle ALU result and illegal-opcode detection.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b0;
        case (opcode_i)
            OP_ADDI: alu_res_s = rs1_i + imm_s;
            OP_ADD:  alu_res_s = rs1_i + rs2_i;
            OP_SUB:  alu_res_s = rs1_i - rs2_i;
            OP_AND:  alu_res_s = rs1_i & rs2_i;
            OP_OR:   alu_res_s = rs1_i | rs2_i;
            OP_XOR:  alu_res_s = rs1_i ^ rs2_i;
            OP_SLL:  alu_res_s = rs1_i << shamt_s;
            OP_SRL:  alu_res_s = rs1_i >> shamt_s;
            OP_SRA:  alu_res_s = XLEN'($signed(rs1_i) >>> shamt_s);
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (rs1_i < rs2_i)};
            OP_LUI:  alu_res_s = {imm_i, {(XLEN-IMM_W){1'b0}}};
            OP_MUL:  alu_res_s = {XLEN{1'b0}};  // MUL result comes from the iterative unit
            default: begin
                alu_res_s = {XLEN{1'b0}};
                alu_ill_s = 1'b1;
            end
        endcase
    end

    // FSM next-state and datapath control.
    always_comb begin
        state_next_s = state_r;
        start_mul_s  = 1'b0;
        step_mul_s   = 1'b0;
        load_alu_s   = 1'b0;
        load_mul_s   = 1'b0;
        drop_out_s   = 1'b0;
        mul_val_s    = acc_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    // Accept implies the output is free, so any old result transfers now.
                    state_next_s = MUL_BUSY;
                    start_mul_s  = 1'b1;
                    drop_out_s   = 1'b1;
                end else if (accept_s) begin
                    load_alu_s = 1'b1;
                end else begin
                    drop_out_s = out_valid_r & out_ready_i;
                end
            end
            MUL_BUSY: begin
                step_mul_s = 1'b1;
                if (last_step_s && out_free_s) begin
                    state_next_s = IDLE;
                    load_mul_s   = 1'b1;
                    mul_val_s    = acc_next_s;
                end else if (last_step_s) begin
                    // The output is still stalled. acc_r keeps the finished product.
                    state_next_s = MUL_HOLD;
                end else begin
                    drop_out_s = out_valid_r & out_ready_i;
                end
            end
            MUL_HOLD: begin
                if (out_free_s) begin
                    state_next_s = IDLE;
                    load_mul_s   = 1'b1;
                    mul_val_s    = acc_r;
                end else begin
                    state_next_s = MUL_HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register and busy flag. Flush sends the FSM back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else if (flush_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Shift-add multiplier registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= {XLEN{1'b0}};
            mplier_r  <= {XLEN{1'b0}};
            acc_r     <= {XLEN{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            mul_opc_r <= {OPC_W{1'b0}};
            mul_rd_r  <= {RD_W{1'b0}};
        end else if (start_mul_s) begin
            mcand_r   <= rs1_i;
            mplier_r  <= rs2_i;
            acc_r     <= {XLEN{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            mul_opc_r <= opcode_i;
            mul_rd_r  <= rd_i;
        end else if (step_mul_s && !flush_i) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    // Output result register. Outputs are held while a stalled result waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            opcode_r    <= {OPC_W{1'b0}};
            rd_r        <= {RD_W{1'b0}};
            result_r    <= {XLEN{1'b0}};
        end else if (flush_i) begin
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (load_alu_s) begin
            out_valid_r <= 1'b1;
            illegal_r   <= alu_ill_s;
            opcode_r    <= opcode_i;
            rd_r        <= rd_i;
            result_r    <= alu_res_s;
        end else if (load_mul_s) begin
            out_valid_r <= 1'b1;
            illegal_r   <= 1'b0;
            opcode_r    <= mul_opc_r;
            rd_r        <= mul_rd_r;
            result_r    <= mul_val_s;
        end else if (drop_out_s) begin
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
        end
    end

    assign out_valid_o  = out_valid_r;
    assign illegal_o    = illegal_r;
    assign opcode_o     = opcode_r;
    assign rd_o         = rd_r;
    assign alu_result_o = result_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage.
//
// A transaction-level model predicts the outputs on every cycle. It uses plain
// arithmetic, a countdown for the multiply, and a pending-result slot. Each
// cycle the bench compares the DUT against the model. Directed scenarios add
// literal expectations. Randomised traffic follows them.
module tb_execute_stage;
    localparam int XLEN  = 32;
    localparam int IMM_W = 20;
    localparam int OPC_W = 5;
    localparam int RD_W  = 5;

    logic             clk = 1'b0;
    logic             rst, flush_i, in_valid_i, in_ready_o;
    logic [OPC_W-1:0] opcode_i, opcode_o;
    logic [XLEN-1:0]  rs1_i, rs2_i, alu_result_o;
    logic [IMM_W-1:0] imm_i;
    logic [RD_W-1:0]  rd_i, rd_o;
    logic             out_valid_o, out_ready_i, illegal_o, busy_o;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(XLEN), .IMM_W(IMM_W), .OPC_W(OPC_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .rd_i(rd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .opcode_o(opcode_o), .rd_o(rd_o), .alu_result_o(alu_result_o),
        .illegal_o(illegal_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid = 1'b0, m_ill = 1'b0, m_hold = 1'b0;
    logic [31:0] m_res = 32'h0, m_pend = 32'h0;
    logic [4:0]  m_opc = 5'h0, m_rd = 5'h0, m_pend_opc = 5'h0, m_pend_rd = 5'h0;
    int          m_left = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Returns {illegal, result} for one operation.
    function automatic logic [32:0] ref_op(input logic [4:0] opc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [19:0] imm);
        logic [31:0] simm;
        logic [63:0] p;
        int          sh;
        simm = {{12{imm[19]}}, imm};
        sh   = int'(b[4:0]);
        p    = {32'h0, a} * {32'h0, b};
        case (opc)
            5'd0:    return {1'b0, a + simm};
            5'd1:    return {1'b0, a + b};
            5'd2:    return {1'b0, a - b};
            5'd3:    return {1'b0, a & b};
            5'd4:    return {1'b0, a | b};
            5'd5:    return {1'b0, a ^ b};
            5'd6:    return {1'b0, a << sh};
            5'd7:    return {1'b0, a >> sh};
            5'd8:    return {1'b0, (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0)};
            5'd9:    return {1'b0, 31'd0, (int'(a) < int'(b))};
            5'd10:   return {1'b0, 31'd0, (a < b)};
            5'd11:   return {1'b0, imm, 12'h0};
            5'd12:   return {1'b0, p[31:0]};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic logic model_rdy();
        return (m_left == 0) && !m_hold && !flush_i && (!m_valid || out_ready_i);
    endfunction

    task automatic present_pending();
        m_valid = 1'b1; m_ill = 1'b0; m_res = m_pend; m_opc = m_pend_opc; m_rd = m_pend_rd;
    endtask

    // Advances the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic        rdy, free;
        logic [32:0] r;
        rdy  = model_rdy();
        free = !m_valid || out_ready_i;
        if (rst) begin
            m_valid = 1'b0; m_ill = 1'b0; m_hold = 1'b0; m_left = 0;
            m_res = 32'h0; m_opc = 5'h0; m_rd = 5'h0;
        end else if (flush_i) begin
            m_valid = 1'b0; m_ill = 1'b0; m_hold = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (free) present_pending();
                else m_hold = 1'b1;
            end else if (m_valid && out_ready_i) begin
                m_valid = 1'b0; m_ill = 1'b0;
            end
        end else if (m_hold) begin
            if (free) begin
                present_pending();
                m_hold = 1'b0;
            end
        end else if (in_valid_i && rdy) begin
            r = ref_op(opcode_i, rs1_i, rs2_i, imm_i);
            if (opcode_i == 5'd12) begin
                m_left = XLEN; m_pend = r[31:0]; m_pend_opc = opcode_i; m_pend_rd = rd_i;
                m_valid = 1'b0; m_ill = 1'b0;
            end else begin
                m_valid = 1'b1; m_ill = r[32]; m_res = r[31:0]; m_opc = opcode_i; m_rd = rd_i;
            end
        end else if (m_valid && out_ready_i) begin
            m_valid = 1'b0; m_ill = 1'b0;
        end
    endtask

    // One cycle: check in_ready, clock the DUT and model, compare outputs.
    task automatic step();
        #1;
        chk1("in_ready", in_ready_o, model_rdy());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk1("out_valid", out_valid_o, m_valid);
        chk1("illegal", illegal_o, m_ill);
        chk1("busy", busy_o, (m_left > 0) || m_hold);
        if (m_valid) begin
            chk32("result", alu_result_o, m_res);
            chk32("rd", 32'(rd_o), 32'(m_rd));
            chk32("opcode", 32'(opcode_o), 32'(m_opc));
        end
    endtask

    task automatic issue(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [19:0] imm, input logic [4:0] rd);
        in_valid_i = 1'b1; opcode_i = opc; rs1_i = a; rs2_i = b; imm_i = imm; rd_i = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        opcode_i = 5'd0; rs1_i = 32'h0; rs2_i = 32'h0; imm_i = 20'h0; rd_i = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        chk1("rst_valid", out_valid_o, 1'b0);
        chk32("rst_result", alu_result_o, 32'h0);
        chk32("rst_rd", 32'(rd_o), 32'h0);
        chk32("rst_opcode", 32'(opcode_o), 32'h0);
        chk1("rst_illegal", illegal_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        rst = 1'b0;

        // ADDI with negative immediate
        issue(5'd0, 32'd5, 32'd0, 20'hFFFFD, 5'd7);
        step();
        in_valid_i = 1'b0;
        chk1("addi_valid", out_valid_o, 1'b1);
        chk32("addi_res", alu_result_o, 32'd2);
        chk32("addi_rd", 32'(rd_o), 32'd7);
        chk32("addi_model", m_res, 32'd2);

        // Back-to-back stream at full throughput
        issue(5'd1, 32'd1, 32'd2, 20'h0, 5'd1);
        chk1("stream_rdy0", in_ready_o, 1'b1); step(); chk32("stream_add", alu_result_o, 32'd3);
        issue(5'd2, 32'd0, 32'd1, 20'h0, 5'd2);
        chk1("stream_rdy1", in_ready_o, 1'b1); step(); chk32("stream_sub", alu_result_o, 32'hFFFFFFFF);
        issue(5'd8, 32'h80000000, 32'd4, 20'h0, 5'd3);
        chk1("stream_rdy2", in_ready_o, 1'b1); step(); chk32("stream_sra", alu_result_o, 32'hF8000000);
        issue(5'd10, 32'd1, 32'hFFFFFFFF, 20'h0, 5'd4);
        chk1("stream_rdy3", in_ready_o, 1'b1); step(); chk32("stream_sltu", alu_result_o, 32'd1);
        chk32("sra_model", ref_op(5'd8, 32'h80000000, 32'd4, 20'h0), 33'h0F8000000);
        in_valid_i = 1'b0;

        // MUL: fixed XLEN-cycle latency
        issue(5'd12, 32'h00010003, 32'h00020005, 20'h0, 5'd9);
        step();
        in_valid_i = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            #1;
            chk1("mul_rdy_low", in_ready_o, 1'b0);
            step();
            if (i < 32) begin
                chk1("mul_busy", busy_o, 1'b1);
                chk1("mul_not_done", out_valid_o, 1'b0);
            end else begin
                chk1("mul_done", out_valid_o, 1'b1);
                chk32("mul_res", alu_result_o, 32'h000B000F);
                chk32("mul_rd", 32'(rd_o), 32'd9);
                chk1("mul_idle", busy_o, 1'b0);
            end
        end
        step();

        // Backpressure: old result stalled, then MUL accepted as it transfers
        out_ready_i = 1'b0;
        issue(5'd1, 32'd1, 32'd1, 20'h0, 5'd2);
        step();
        issue(5'd12, 32'd7, 32'd6, 20'h0, 5'd5);
        repeat (3) begin
            #1;
            chk1("bp_rdy_low", in_ready_o, 1'b0);
            step();
            chk32("bp_hold_old", alu_result_o, 32'd2);
        end
        out_ready_i = 1'b1;
        step();
        chk1("bp_old_gone", out_valid_o, 1'b0);
        chk1("bp_busy", busy_o, 1'b1);
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        repeat (32) step();
        chk1("bp_mul_valid", out_valid_o, 1'b1);
        chk32("bp_mul_res", alu_result_o, 32'd42);
        repeat (3) step();
        chk32("bp_mul_stable", alu_result_o, 32'd42);
        out_ready_i = 1'b1;
        step();
        chk1("bp_drained", out_valid_o, 1'b0);

        // Flush 10 cycles into a MUL
        issue(5'd12, 32'd3, 32'd3, 20'h0, 5'd6);
        step();
        in_valid_i = 1'b0;
        repeat (9) step();
        flush_i = 1'b1;
        issue(5'd1, 32'd9, 32'd9, 20'h0, 5'd8);
        chk1("flush_rdy_low", in_ready_o, 1'b0);
        step();
        chk1("flush_valid", out_valid_o, 1'b0);
        chk1("flush_busy", busy_o, 1'b0);
        flush_i = 1'b0;
        issue(5'd1, 32'd4, 32'd4, 20'h0, 5'd8);
        step();
        in_valid_i = 1'b0;
        chk32("flush_add", alu_result_o, 32'd8);

        // Illegal opcode
        issue(5'd31, 32'd5, 32'd6, 20'h0, 5'd1);
        step();
        in_valid_i = 1'b0;
        chk1("ill_valid", out_valid_o, 1'b1);
        chk1("ill_flag", illegal_o, 1'b1);
        chk32("ill_res", alu_result_o, 32'h0);
        step();

        // Reset in the middle of a MUL
        issue(5'd12, 32'd11, 32'd13, 20'h0, 5'd3);
        step();
        in_valid_i = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk1("rstm_valid", out_valid_o, 1'b0);
        chk1("rstm_busy", busy_o, 1'b0);
        chk32("rstm_res", alu_result_o, 32'h0);
        chk32("rstm_rd", 32'(rd_o), 32'h0);
        rst = 1'b0;

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            int pick;
            rst         = ($urandom_range(0, 299) == 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            pick        = int'($urandom_range(0, 15));
            opcode_i    = (pick == 15) ? 5'($urandom_range(13, 31)) : 5'(pick);
            rs1_i       = $urandom;
            rs2_i       = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 5) == 0) rs1_i = 32'h80000000;
            imm_i       = 20'($urandom);
            rd_i        = 5'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
